// File: rtl/wb_seq_pkg.sv
// Shared types and constants for the Wishbone sequence initiator.
package wb_seq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StGap,
      StFin
   } state_e;

   localparam logic [3:0]  SEL_ALL         = 4'b1111;
   localparam int unsigned TIMEOUT_DEFAULT = 255;
   localparam int unsigned TO_W            = 16;

endpackage

// File: rtl/wb_seq_timeout.sv
// Loadable down-counter; expired is high once the count reaches zero.
module wb_seq_timeout
   import wb_seq_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [TO_W-1:0] load_val,
   input  logic            run,
   output logic            expired
);

   logic [TO_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (run && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/wb_seq_master.sv
// Wishbone classic initiator issuing single-beat read/write sequences.
// Optional per-beat ack timeout is enabled by defining WBM_TIMEOUT_EN.
module wb_seq_master
   import wb_seq_pkg::*;
#(
   parameter logic [23:0] ADDR_HI = 24'h000000,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [7:0]  cmd_addr,
   input  logic [7:0]  cmd_len,
   input  logic [31:0] cmd_seed,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i
);

   state_e      state_q, state_d;
   logic [8:0]  beat_q, beat_d;
   logic        we_q, we_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  len_q, len_d;
   logic [31:0] seed_q, seed_d;
   logic        rd_valid_q, rd_valid_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        cyc_q, stb_q, wbm_we_q, busy_q, done_q, ready_q;
   logic [3:0]  sel_q;
   logic [7:0]  adr_q;
   logic [31:0] dat_q;
   logic        cyc_d, stb_d;

`ifdef WBM_TIMEOUT_EN
   logic err_q, err_d;
   logic to_expired;

   wb_seq_timeout u_timeout (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_i),
      .load     ((state_d == StReq) && (state_q != StReq)),
      .load_val (TO_W'(TIMEOUT - 1)),
      .run      (state_q == StReq),
      .expired  (to_expired)
   );

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      we_d       = we_q;
      addr_d     = addr_q;
      len_d      = len_q;
      seed_d     = seed_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
`ifdef WBM_TIMEOUT_EN
      err_d      = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               we_d    = cmd_we;
               addr_d  = cmd_addr;
               len_d   = cmd_len;
               seed_d  = cmd_seed;
               beat_d  = 9'd0;
`ifdef WBM_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = StReq;
            end
         end
         StReq: begin
            if (wbm_ack_i) begin
               rd_valid_d = ~we_q;
               if (!we_q) rd_data_d = wbm_dat_i;
               // Counter is 9 bits but stops at len, so 256 beats never wrap it.
               if (beat_q == {1'b0, len_q}) begin
                  state_d = StFin;
               end else begin
                  beat_d  = beat_q + 9'd1;
                  state_d = StGap;
               end
            end
`ifdef WBM_TIMEOUT_EN
            else if (to_expired) begin
               err_d   = 1'b1;
               state_d = StFin;
            end
`endif
         end
         StGap:   state_d = StReq;
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Bus outputs are registered from the next state so they change on the edge.
   assign cyc_d = (state_d == StReq) || (state_d == StGap);
   assign stb_d = (state_d == StReq);

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q    <= StIdle;
         beat_q     <= 9'd0;
         we_q       <= 1'b0;
         addr_q     <= 8'd0;
         len_q      <= 8'd0;
         seed_q     <= 32'd0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 32'd0;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         wbm_we_q   <= 1'b0;
         sel_q      <= 4'b0000;
         adr_q      <= 8'd0;
         dat_q      <= 32'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= 1'b1;
`ifdef WBM_TIMEOUT_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         seed_q     <= seed_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         cyc_q      <= cyc_d;
         stb_q      <= stb_d;
         wbm_we_q   <= cyc_d & we_d;
         sel_q      <= stb_d ? SEL_ALL : 4'b0000;
         adr_q      <= addr_d + beat_d[7:0];
         dat_q      <= seed_d + 32'(beat_d);
         busy_q     <= (state_d != StIdle);
         done_q     <= (state_d == StFin);
         ready_q    <= (state_d == StIdle);
`ifdef WBM_TIMEOUT_EN
         err_q      <= err_d;
`endif
      end
   end

   assign cmd_ready = ready_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = stb_q;
   assign wbm_we_o  = wbm_we_q;
   assign wbm_sel_o = sel_q;
   assign wbm_adr_o = {ADDR_HI, adr_q};
   assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_seq_master.sv
// Self-checking bench for wb_seq_master: SRAM slave model plus transfer scoreboard.
module tb_wb_seq_master;

   localparam logic [23:0] TB_ADDR_HI = 24'hA5C300;
`ifdef WBM_TIMEOUT_EN
   localparam int unsigned TB_TO = 4;
`else
   localparam int unsigned TB_TO = 255;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_we = 1'b0;
   logic [7:0]  cmd_addr = 8'd0, cmd_len = 8'd0;
   logic [31:0] cmd_seed = 32'd0;
   logic        cmd_ready, rd_valid, busy, done, err;
   logic [31:0] rd_data;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o;
   logic        ack = 1'b0;
   logic [31:0] dat_i = 32'd0;

   int errors = 0, checks = 0;
   int slave_lat = 0, wcnt = 0;
   logic slave_mute = 1'b0;
   int done_cnt = 0, phase_cnt = 0, stb_hi_cnt = 0;
   logic prev_ack_rd = 0, prev_ack_any = 0, prev_done = 0, stb_prev = 0;

   logic [31:0] slave_mem [256];
   logic [31:0] model_mem [256];
   logic [31:0] log_adr [$];
   logic [31:0] log_dat [$];
   logic        log_we [$];
   logic [31:0] rd_q [$];

   wb_seq_master #(
      .ADDR_HI (TB_ADDR_HI),
      .TIMEOUT (TB_TO)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .cmd_seed  (cmd_seed),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .wbm_cyc_o (cyc),
      .wbm_stb_o (stb),
      .wbm_we_o  (we),
      .wbm_sel_o (sel),
      .wbm_adr_o (adr),
      .wbm_dat_o (dat_o),
      .wbm_ack_i (ack),
      .wbm_dat_i (dat_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor first (uses last negedge's slave state), then the slave model.
   always @(negedge clk) begin
      if (!rst_n) begin
         ack = 1'b0; wcnt = 0;
         prev_ack_rd = 0; prev_ack_any = 0; prev_done = 0; stb_prev = 0;
      end else begin
         if (rd_valid || prev_ack_rd) check("rd_valid_timing", rd_valid, prev_ack_rd);
         if (rd_valid) rd_q.push_back(rd_data);
         if (prev_done) begin
            check("busy_after_done", busy, 1'b0);
            check("ready_after_done", cmd_ready, 1'b1);
         end
         if (done) begin
            done_cnt++;
            if (!slave_mute) check("done_after_ack", prev_ack_any, 1'b1);
         end
         if (stb && !stb_prev) phase_cnt++;
         if (stb) stb_hi_cnt++;
         stb_prev = stb;
         prev_done = done;
         prev_ack_rd = 0;
         prev_ack_any = 0;
         if (cyc && stb) begin
            if (wcnt >= slave_lat && !slave_mute) begin
               ack = 1'b1;
               dat_i = slave_mem[adr[7:0]];
               if (we) slave_mem[adr[7:0]] = dat_o;
               check("adr_hi", {8'd0, adr[31:8]}, {8'd0, TB_ADDR_HI});
               check("sel", {28'd0, sel}, 32'hF);
               log_adr.push_back(adr);
               log_dat.push_back(dat_o);
               log_we.push_back(we);
               prev_ack_any = 1;
               prev_ack_rd = !we;
            end else begin
               ack = 1'b0;
            end
            wcnt++;
         end else begin
            ack = 1'b0;
            wcnt = 0;
         end
      end
   end

   task automatic issue_cmd(input logic w, input logic [7:0] a, input logic [7:0] len,
                            input logic [31:0] seed, input int lat);
      int n;
      slave_lat = lat;
      log_adr.delete(); log_dat.delete(); log_we.delete(); rd_q.delete();
      done_cnt = 0; phase_cnt = 0; stb_hi_cnt = 0;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
      check("ready_before_cmd", cmd_ready, 1'b1);
      cmd_we = w; cmd_addr = a; cmd_len = len; cmd_seed = seed; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      check("busy_on_accept", busy, 1'b1);
      check("ready_low_on_accept", cmd_ready, 1'b0);
      check("err_clear_on_accept", err, 1'b0);
   endtask

   task automatic run_cmd(input logic w, input logic [7:0] a, input logic [7:0] len,
                          input logic [31:0] seed, input int lat);
      int n, budget, nb;
      logic [7:0] ea;
      issue_cmd(w, a, len, seed, lat);
      // A command offered while busy must be dropped, not queued.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_we = ~w; cmd_addr = 8'($urandom); cmd_len = 8'd5;
      @(negedge clk);
      cmd_valid = 1'b0;
      budget = (int'(len) + 1) * (lat + 3) + 20;
      n = 0;
      while (done_cnt == 0 && n < budget) begin @(negedge clk); #2; n++; end
      check("done_seen", 32'(done_cnt > 0), 32'd1);
      repeat (3) @(negedge clk);
      #2;
      nb = int'(len) + 1;
      check("done_once", done_cnt, 1);
      check("beat_count", log_adr.size(), nb);
      check("stb_phases", phase_cnt, nb);
      check("err_end", err, 1'b0);
      for (int i = 0; i < nb && i < log_adr.size(); i++) begin
         ea = a + 8'(i);
         check("beat_adr", log_adr[i], {TB_ADDR_HI, ea});
         check("beat_we", log_we[i], w);
         if (w) begin
            check("beat_dat", log_dat[i], seed + 32'(i));
            model_mem[ea] = seed + 32'(i);
         end
      end
      if (!w) begin
         check("rd_count", rd_q.size(), nb);
         for (int i = 0; i < nb && i < rd_q.size(); i++) begin
            ea = a + 8'(i);
            check("rd_data", rd_q[i], model_mem[ea]);
         end
      end else begin
         check("no_rd_on_write", rd_q.size(), 0);
      end
   endtask

   initial begin
      int n, rd_before, done_before;
      logic [31:0] v;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         slave_mem[i] = v;
         model_mem[i] = v;
      end

      #12;
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_cyc", cyc, 1'b0);
      check("rst_stb", stb, 1'b0);
      check("rst_we", we, 1'b0);
      check("rst_sel", {28'd0, sel}, 32'd0);
      check("rst_adr", adr, {TB_ADDR_HI, 8'h00});
      check("rst_dat", dat_o, 32'd0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      run_cmd(1'b1, 8'h10, 8'd3, 32'hA0, 0);
      run_cmd(1'b0, 8'h10, 8'd3, 32'h0, 0);
      check("rd0_is_A0", rd_q.size() > 0 ? rd_q[0] : 32'hX, 32'hA0);
      run_cmd(1'b1, 8'hFE, 8'd3, $urandom, 1);
      run_cmd(1'b0, 8'hFE, 8'd3, 32'h0, 0);
      run_cmd(1'b1, 8'h00, 8'd255, $urandom, 3);
      run_cmd(1'b0, 8'h80, 8'd255, 32'h0, 0);

      // Reset during beat 2 of an 8-beat read.
      issue_cmd(1'b0, 8'h20, 8'd7, 32'h0, 2);
      n = 0;
      do begin @(negedge clk); #2; n++; end
      while (!(log_adr.size() == 2 && stb && !ack) && n < 200);
      check("reached_beat2", 32'(n < 200), 32'd1);
      rd_before = rd_q.size();
      done_before = done_cnt;
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_cyc", cyc, 1'b0);
      check("mid_rst_stb", stb, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      check("mid_rst_no_done", done_cnt, done_before);
      check("mid_rst_no_rd", rd_q.size(), rd_before);
      check("mid_rst_ready", cmd_ready, 1'b1);
      run_cmd(1'b1, 8'h40, 8'd5, $urandom, 1);

      for (int k = 0; k < 6; k++) begin
         run_cmd(1'($urandom), 8'($urandom), 8'($urandom_range(0, 20)), $urandom,
                 int'($urandom_range(0, 3)));
      end

`ifdef WBM_TIMEOUT_EN
      slave_mute = 1'b1;
      issue_cmd(1'b1, 8'h30, 8'd3, 32'h55, 0);
      n = 0;
      while (done_cnt == 0 && n < 50) begin @(negedge clk); #2; n++; end
      check("to_done_seen", 32'(done_cnt > 0), 32'd1);
      repeat (2) @(negedge clk);
      #2;
      check("to_stb_cycles", stb_hi_cnt, 4);
      check("to_err", err, 1'b1);
      check("to_done_once", done_cnt, 1);
      check("to_no_beats", log_adr.size(), 0);
      slave_mute = 1'b0;
      run_cmd(1'b0, 8'h30, 8'd2, 32'h0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_seq_master.md
# wb_seq_master

Wishbone classic initiator that issues sequences of single-beat read or write cycles toward the user-area SRAM slave. It is driven by a one-shot command port from local control logic: start word, length, direction, write seed. Read data is returned on a valid-qualified stream, and completion is reported with a done pulse and an error flag. It sits between test/DMA control logic and the 256×32 SRAM's Wishbone port, as the initiator end of that interface.

## Interface
- ADDR_HI, 24'h000000, fixed upper address bits driven on wbm_adr_o[31:8]
- TIMEOUT, 255, max cycles to wait for ack per beat (used only with WBM_TIMEOUT_EN); must be ≥1

- wb_clk_i  in  1  sole clock, rising edge
- wb_rst_i  in  1  reset: asynchronous assert, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_we  in  1  1 = write sequence, 0 = read sequence
- cmd_addr  in  8  start word index
- cmd_len  in  8  beats minus one (0 → 1 beat, 255 → 256 beats)
- cmd_seed  in  32  write data for beat 0; beat n writes seed+n (mod 2^32)
- rd_valid  out  1  one-cycle pulse per read beat
- rd_data  out  32  read word, valid with rd_valid
- busy  out  1  high from command accept until done
- done  out  1  one-cycle pulse at sequence end
- err  out  1  sticky timeout flag, cleared on next command accept
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone strobes
- wbm_sel_o  out  4  always 4'b1111 while stb high, else 0
- wbm_adr_o  out  32  {ADDR_HI, word index}
- wbm_dat_o  out  32  write data
- wbm_ack_i  in  1  slave acknowledge
- wbm_dat_i  in  32  slave read data

## Operation
- All outputs reset to 0 except cmd_ready = 1; wbm_adr_o = {ADDR_HI, 8'h00}.
- States: IDLE, REQ, GAP, FIN.
- IDLE: cmd_ready=1. On cmd_valid: latch fields, beat counter = 0, clear err, busy=1 → REQ.
- REQ: cyc=stb=1, we=cmd_we, adr index = cmd_addr + beat (8-bit, wraps 255→0), dat_o = seed+beat. On ack: read beat registers wbm_dat_i into rd_data and pulses rd_valid the next cycle. If beat == cmd_len → FIN, else beat++ → GAP.
- GAP: stb=0, cyc=1 (cycle held across the sequence), one cycle → REQ.
- FIN: cyc=stb=0, done=1 for one cycle, busy=0 → IDLE.
- ack outside REQ is ignored; cmd_valid outside IDLE is ignored (not queued).
- Beat counter 9 bits internally; a 256-beat sequence terminates on beat == 255 and never overflows.

## Timing
- Accept edge T0; stb high from T0+1. Ack-to-next-stb: 2 cycles (GAP). Zero-wait slave: 2 cycles/beat.
- rd_valid asserts the cycle after the ack edge. done asserts the cycle after the final ack. cmd_ready returns the cycle after done.
- wbm_* outputs registered; no combinational path from wbm_ack_i to any output.
- Reset mid-sequence: cyc/stb drop immediately (async), no done, and no rd_valid is produced. Busy ends.

## Configuration
- WBM_TIMEOUT_EN defined: per-beat counter starts at REQ entry. If TIMEOUT cycles elapse with no ack, go to FIN with err=1. Remaining beats are abandoned, and done still pulses.
- Undefined: REQ waits indefinitely; err is tied to 0 and the counter logic is absent.

## Structure
- Package wb_seq_pkg: state enum, SEL_ALL = 4'b1111, default TIMEOUT constant.
- Sub-module wb_seq_timeout: loadable down-counter with expiry flag. Instantiated only under WBM_TIMEOUT_EN.

## Test plan
- Write cmd_addr=8'h10, len=3, seed=32'hA0: words 0x10–0x13 receive A0–A3, 4 stb phases, exactly one done, err=0.
- Read back same range with a zero-wait model: rd_valid pulses ×4 with data A0..A3 in order, each one cycle after its ack.
- Wrap: write addr=8'hFE, len=3 → indices FE, FF, 00, 01; wbm_adr_o[31:8] == ADDR_HI throughout.
- Slave with 3-cycle ack latency, len=255: 256 acks, beat counter terminates, done once, busy low the following cycle.
- WBM_TIMEOUT_EN with TIMEOUT=4 and a slave that never acks: stb drops after 4 cycles, err=1, done pulses. The next accepted command clears err.
- Assert wb_rst_i low mid-sequence (beat 2 of 8): cyc/stb low in the same cycle, and no done. After release, cmd_ready=1 and a new command runs normally.
